// File: rtl/axi_sram_bridge_pkg.sv
// rtl/axi_sram_bridge_pkg.sv - FSM encodings and AXI constants for axi_sram_bridge
package axi_sram_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_WAIT = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW_W = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] ID_INST     = 4'd0;
  localparam logic [3:0] ID_DATA     = 4'd1;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR are the only responses treated as bus errors
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/bridge_wstrb_gen.sv
// rtl/bridge_wstrb_gen.sv - byte-lane write strobe from access size and low address bits
module bridge_wstrb_gen (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  // byte: one lane, half: lower or upper pair, word (and unused code 3): all lanes
  always_comb begin
    wstrb = 4'b1111;
    case (size)
      2'd0:    wstrb = 4'b0001 << addr_lo;
      2'd1:    wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/axi_sram_bridge.sv
// rtl/axi_sram_bridge.sv - SRAM-like inst/data ports to single-beat AXI3 master; BRIDGE_BUS_ERR_EN adds inst_err/data_err
module axi_sram_bridge
  import axi_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              inst_req,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
`ifdef BRIDGE_BUS_ERR_EN
  ,
  output logic              inst_err,
  output logic              data_err
`endif
);

  r_state_t          r_state;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [1:0]        ar_size_q;
  logic [3:0]        ar_id_q;

  w_state_t          w_state;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [1:0]        aw_size_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_done;
  logic              w_done;

  logic r_idle;
  logic w_idle;
  logic wr_hazard;
  logic data_rd_go;
  logic data_wr_go;
  logic inst_go;
  logic r_fire;
  logic r_is_data;
  logic rd_data_fire;
  logic b_fire;

  assign r_idle = (r_state == R_IDLE);
  assign w_idle = (w_state == W_IDLE);

  // a load may not overtake a store to the same word that is still in flight
  assign wr_hazard  = !w_idle && (data_addr[ADDR_W-1:2] == aw_addr_q[ADDR_W-1:2]);
  assign data_rd_go = r_idle && data_req && !data_wr && !wr_hazard;
  assign inst_go    = r_idle && inst_req && !data_rd_go;
  assign data_wr_go = w_idle && data_req && data_wr;

  assign inst_addr_ok = inst_go;
  assign data_addr_ok = data_rd_go || data_wr_go;

  // rready is permanently high in R_WAIT, so rvalid alone completes the beat
  assign r_fire       = (r_state == R_WAIT) && rvalid;
  assign r_is_data    = (ar_id_q == ID_DATA);
  assign rd_data_fire = r_fire && r_is_data;

  // a data read beat takes the shared data_data_ok pulse; the write response waits a cycle
  assign bready = (w_state == W_RESP) && !rd_data_fire;
  assign b_fire = bvalid && bready;

  assign inst_data_ok = r_fire && !r_is_data;
  assign inst_rdata   = inst_data_ok ? rdata : '0;
  assign data_data_ok = rd_data_fire || b_fire;
  assign data_rdata   = rd_data_fire ? rdata : '0;

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, ar_size_q};
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (r_state == R_AR);
  assign rready  = (r_state == R_WAIT);

  assign awid    = ID_DATA;
  assign awaddr  = aw_addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, aw_size_q};
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = (w_state == W_AW_W) && !aw_done;
  assign wid     = ID_DATA;
  assign wdata   = wdata_q;
  assign wlast   = 1'b1;
  assign wvalid  = (w_state == W_AW_W) && !w_done;

  bridge_wstrb_gen u_wstrb_gen (
    .size    (aw_size_q),
    .addr_lo (aw_addr_q[1:0]),
    .wstrb   (wstrb)
  );

`ifdef BRIDGE_BUS_ERR_EN
  assign inst_err = inst_data_ok && resp_is_err(rresp);
  assign data_err = (rd_data_fire && resp_is_err(rresp)) || (b_fire && resp_is_err(bresp));

  logic unused_inputs;
  assign unused_inputs = ^{rid, rlast, bid};
`else
  logic unused_inputs;
  assign unused_inputs = ^{rid, rlast, bid, rresp, bresp};
`endif

  // read channel: latch the winning request, present AR, then take the single R beat
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      ar_size_q <= 2'd0;
      ar_id_q   <= ID_INST;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (data_rd_go) begin
            ar_addr_q <= data_addr;
            ar_size_q <= data_size;
            ar_id_q   <= ID_DATA;
            r_state   <= R_AR;
          end else if (inst_go) begin
            ar_addr_q <= inst_addr;
            ar_size_q <= inst_size;
            ar_id_q   <= ID_INST;
            r_state   <= R_AR;
          end
        end
        R_AR: begin
          if (arready) r_state <= R_WAIT;
        end
        R_WAIT: begin
          if (rvalid) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // write channel: AW and W complete independently, then wait for the B response
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      aw_size_q <= 2'd0;
      wdata_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (data_wr_go) begin
            aw_addr_q <= data_addr;
            aw_size_q <= data_size;
            wdata_q   <= data_wdata;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            w_state   <= W_AW_W;
          end
        end
        W_AW_W: begin
          if ((aw_done || awready) && (w_done || wready)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_state <= W_RESP;
          end else begin
            if (awready) aw_done <= 1'b1;
            if (wready)  w_done  <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_fire) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// tb/tb_axi_sram_bridge.sv - scoreboard bench for axi_sram_bridge with a behavioural AXI slave
module tb_axi_sram_bridge;

  logic        clk;
  logic        aresetn;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
`ifdef BRIDGE_BUS_ERR_EN
  logic        inst_err, data_err;
`endif

  axi_sram_bridge dut (
    .aclk(clk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef BRIDGE_BUS_ERR_EN
    , .inst_err(inst_err), .data_err(data_err)
`endif
  );

  typedef struct { logic [31:0] addr; logic [3:0] id; logic [2:0] size; } ar_exp_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; } aw_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
  typedef struct { logic [31:0] data; logic err; int lat; int cyc0; } rsp_exp_t;

  ar_exp_t  exp_ar[$];
  aw_exp_t  exp_aw[$];
  w_exp_t   exp_w[$];
  rsp_exp_t exp_inst[$];
  rsp_exp_t exp_drd[$];
  logic     exp_dwr[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_drd_cyc = -10;
  int last_dwr_cyc = -10;

  logic       r_hold;
  logic [1:0] rresp_cfg;
  logic [1:0] bresp_cfg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no_event (cycle %0d)", name, cyc);
  endtask

  // Behavioural slave: rdata = ~araddr, B after both AW and W, rvalid held back by r_hold
  initial begin : slave
    logic        pend, aw_got, w_got;
    logic [31:0] pend_addr;
    logic [3:0]  pend_id;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
    pend = 0; aw_got = 0; w_got = 0; pend_addr = '0; pend_id = '0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (ar_hs) begin pend = 1; pend_addr = araddr; pend_id = arid; end
      @(posedge clk); #1;
      if (!aresetn) begin
        pend = 0; aw_got = 0; w_got = 0; rvalid = 0; bvalid = 0;
      end else begin
        if (r_hs) rvalid = 0;
        if (pend && !rvalid && !r_hold) begin
          rvalid = 1; rdata = ~pend_addr; rid = pend_id; rresp = rresp_cfg; pend = 0;
        end
        if (aw_hs) aw_got = 1;
        if (w_hs)  w_got = 1;
        if (b_hs)  bvalid = 0;
        if (aw_got && w_got && !bvalid) begin
          bvalid = 1; bresp = bresp_cfg; aw_got = 0; w_got = 0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a handshake or a data_ok pulse
  initial begin : monitor
    ar_exp_t  ea;
    aw_exp_t  eaw;
    w_exp_t   ew;
    rsp_exp_t er;
    logic     ewr;
    logic     rd_f, wr_f;
    forever begin
      @(negedge clk);
      if (aresetn) begin
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) unexpected("ar_handshake");
          else begin
            ea = exp_ar.pop_front();
            chk("araddr", araddr, ea.addr);
            chk("arid", arid, ea.id);
            chk("arsize", arsize, ea.size);
            chk("ar_const", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
          end
        end
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) unexpected("aw_handshake");
          else begin
            eaw = exp_aw.pop_front();
            chk("awaddr", awaddr, eaw.addr);
            chk("awsize", awsize, eaw.size);
            chk("aw_const", {awid, awlen, awburst, awlock, awcache, awprot}, {4'd1, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
          end
        end
        if (wvalid && wready) begin
          if (exp_w.size() == 0) unexpected("w_handshake");
          else begin
            ew = exp_w.pop_front();
            chk("wdata", wdata, ew.data);
            chk("wstrb", wstrb, ew.strb);
            chk("w_const", {wlast, wid}, {1'b1, 4'd1});
          end
        end
        if (inst_data_ok) begin
          if (exp_inst.size() == 0) unexpected("inst_data_ok");
          else begin
            er = exp_inst.pop_front();
            chk("inst_rdata", inst_rdata, er.data);
            if (er.lat >= 0) chk("inst_latency", cyc - er.cyc0, er.lat);
`ifdef BRIDGE_BUS_ERR_EN
            chk("inst_err", inst_err, er.err);
`endif
          end
        end
        if (data_data_ok) begin
          rd_f = rvalid && rready && (rid == 4'd1);
          wr_f = bvalid && bready;
          chk("data_ok_exclusive", rd_f && wr_f, 1'b0);
          if (rd_f) begin
            last_drd_cyc = cyc;
            if (exp_drd.size() == 0) unexpected("data_read_ok");
            else begin
              er = exp_drd.pop_front();
              chk("data_rdata", data_rdata, er.data);
`ifdef BRIDGE_BUS_ERR_EN
              chk("data_err_rd", data_err, er.err);
`endif
            end
          end else if (wr_f) begin
            last_dwr_cyc = cyc;
            if (exp_dwr.size() == 0) unexpected("data_write_ok");
            else begin
              ewr = exp_dwr.pop_front();
`ifdef BRIDGE_BUS_ERR_EN
              chk("data_err_wr", data_err, ewr);
`else
              chk("write_ok_on_bvalid", bvalid, 1'b1);
`endif
            end
          end else unexpected("data_data_ok_no_beat");
        end
      end
    end
  end

  task automatic data_go(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, output int acc);
    data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    acc = -1;
    for (int i = 0; i < 40 && acc < 0; i++) begin
      @(negedge clk);
      if (data_addr_ok) acc = cyc;
    end
    @(posedge clk); #1;
    data_req = 1'b0;
    chk("data_accept", acc >= 0, 1'b1);
  endtask

  task automatic inst_go(input logic [31:0] addr, output int acc);
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = addr;
    acc = -1;
    for (int i = 0; i < 40 && acc < 0; i++) begin
      @(negedge clk);
      if (inst_addr_ok) acc = cyc;
    end
    @(posedge clk); #1;
    inst_req = 1'b0;
    chk("inst_accept", acc >= 0, 1'b1);
  endtask

  task automatic drain(input bit rd_only);
    int left;
    left = 1;
    for (int i = 0; i < 100 && left != 0; i++) begin
      @(posedge clk); #1;
      left = exp_drd.size() + exp_inst.size() + exp_ar.size();
      if (!rd_only) left = left + exp_aw.size() + exp_w.size() + exp_dwr.size();
    end
    chk("drain", left, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int acc, acc2, c0;
    aresetn = 0; inst_req = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 1; awready = 1; wready = 1;
    rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    bid = 4'd1; bresp = 0; bvalid = 0;
    r_hold = 0; rresp_cfg = 2'b00; bresp_cfg = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("rst_readies", {rready, bready}, 2'b00);
    chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 4'b0000);
    chk("rst_wdata", wdata, 32'h0);
    aresetn = 1;
    @(posedge clk); #1;

    // 1: lone fetch, zero-wait slave, data_ok in the third cycle
    exp_ar.push_back('{32'hBFC00000, 4'd0, 3'b010});
    inst_go(32'hBFC00000, acc);
    exp_inst.push_back('{32'h403FFFFF, 1'b0, 2, acc});
    drain(0);

    // 2: fetch and load in the same cycle, load wins, fetch follows the load's R beat
    exp_ar.push_back('{32'h80001000, 4'd1, 3'b010});
    exp_ar.push_back('{32'hBFC00004, 4'd0, 3'b010});
    exp_drd.push_back('{32'h7FFFEFFF, 1'b0, -1, 0});
    inst_req = 1; inst_size = 2'd2; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80001000;
    @(negedge clk);
    chk("arb_data_ok", data_addr_ok, 1'b1);
    chk("arb_inst_lose", inst_addr_ok, 1'b0);
    @(posedge clk); #1;
    data_req = 0;
    inst_go(32'hBFC00004, acc);
    chk("inst_after_data", acc, last_drd_cyc + 1);
    exp_inst.push_back('{32'h403FFFFB, 1'b0, -1, 0});
    drain(0);

    // 3: halfword store to the upper lanes
    exp_aw.push_back('{32'h80000002, 3'b001});
    exp_w.push_back('{32'hABCD0000, 4'b1100});
    exp_dwr.push_back(1'b0);
    data_go(1'b1, 2'd1, 32'h80000002, 32'hABCD0000, acc);
    drain(0);

    // 4: awready held off 4 cycles while W completes at once
    awready = 0;
    exp_aw.push_back('{32'h80000104, 3'b010});
    exp_w.push_back('{32'h11223344, 4'b1111});
    exp_dwr.push_back(1'b0);
    data_go(1'b1, 2'd2, 32'h80000104, 32'h11223344, acc);
    @(negedge clk);
    chk("aw_w_first", {awvalid, wvalid}, 2'b11);
    repeat (3) begin
      @(negedge clk);
      chk("aw_held_w_dropped", {awvalid, wvalid}, 2'b10);
      chk("bready_before_aw", bready, 1'b0);
    end
    @(posedge clk); #1;
    awready = 1;
    drain(0);

    // 5: load to the word of a pending store stalls; a load elsewhere proceeds
    awready = 0;
    exp_aw.push_back('{32'h80000010, 3'b010});
    exp_w.push_back('{32'h55AA55AA, 4'b1111});
    exp_dwr.push_back(1'b0);
    data_go(1'b1, 2'd2, 32'h80000010, 32'h55AA55AA, acc);
    data_req = 1; data_wr = 0; data_size = 2'd0; data_addr = 32'h80000013;
    repeat (3) begin
      @(negedge clk);
      chk("hazard_stall", data_addr_ok, 1'b0);
    end
    @(posedge clk); #1;
    data_req = 0;
    c0 = cyc;
    exp_ar.push_back('{32'h80000020, 4'd1, 3'b010});
    exp_drd.push_back('{32'h7FFFFFDF, 1'b0, -1, 0});
    data_go(1'b0, 2'd2, 32'h80000020, 32'h0, acc2);
    chk("nohazard_go", acc2, c0);
    drain(1);
    exp_ar.push_back('{32'h80000013, 4'd1, 3'b000});
    exp_drd.push_back('{32'h7FFFFFEC, 1'b0, -1, 0});
    awready = 1;
    data_go(1'b0, 2'd0, 32'h80000013, 32'h0, acc);
    chk("hazard_release", acc, last_dwr_cyc + 1);
    drain(0);

    // 6: data R beat and B response in the same cycle, read reported first
    arready = 0; awready = 0;
    exp_aw.push_back('{32'h80000300, 3'b010});
    exp_w.push_back('{32'hCAFEF00D, 4'b1111});
    exp_dwr.push_back(1'b0);
    data_go(1'b1, 2'd2, 32'h80000300, 32'hCAFEF00D, acc);
    exp_ar.push_back('{32'h80000200, 4'd1, 3'b010});
    exp_drd.push_back('{32'h7FFFFDFF, 1'b0, -1, 0});
    data_go(1'b0, 2'd2, 32'h80000200, 32'h0, acc);
    arready = 1; awready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("coincide_valids", {rvalid, bvalid}, 2'b11);
    chk("coincide_bready", bready, 1'b0);
    @(negedge clk);
    chk("coincide_bready_next", bready, 1'b1);
    @(posedge clk); #1;
    drain(0);
    chk("read_before_write", last_dwr_cyc, last_drd_cyc + 1);

    // 7: reset while waiting for R drops the fetch
    r_hold = 1;
    exp_ar.push_back('{32'hBFC00100, 4'd0, 3'b010});
    inst_go(32'hBFC00100, acc);
    @(negedge clk);
    @(negedge clk);
    chk("rwait_rready", rready, 1'b1);
    aresetn = 0;
    @(negedge clk);
    chk("rst_mid_valid", {arvalid, rready}, 2'b00);
    chk("rst_mid_ok", inst_data_ok, 1'b0);
    aresetn = 1;
    r_hold = 0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    drain(0);

`ifdef BRIDGE_BUS_ERR_EN
    // 8: SLVERR on a data read raises data_err
    rresp_cfg = 2'b10;
    exp_ar.push_back('{32'h80000400, 4'd1, 3'b010});
    exp_drd.push_back('{32'h7FFFFBFF, 1'b1, -1, 0});
    data_go(1'b0, 2'd2, 32'h80000400, 32'h0, acc);
    drain(0);
    rresp_cfg = 2'b00;
`endif

    chk("queues_empty", exp_ar.size() + exp_aw.size() + exp_w.size() +
        exp_inst.size() + exp_drd.size() + exp_dwr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
